// File: rtl/apb2axi_rd_tag_scheduler.sv
`default_nettype none
// ============================================================================
// apb2axi_rd_tag_scheduler : read-path admission control and per-ID R tracking
// Revision: 1.0
// ============================================================================
module apb2axi_rd_tag_scheduler #(
    parameter int AXI_ID_W        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_W           = 4
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   fifo_valid,
    input  logic [AXI_ID_W-1:0]                    fifo_tag,
    input  logic [LEN_W-1:0]                       fifo_len,
    output logic                                   fifo_ready,
    output logic                                   bld_valid,
    input  logic                                   bld_ready,
    input  logic                                   r_fire,
    input  logic [AXI_ID_W-1:0]                    r_id,
    input  logic [1:0]                             r_resp,
    input  logic                                   r_last,
    output logic                                   cmpl_valid,
    output logic [AXI_ID_W-1:0]                    cmpl_tag,
    output logic [1:0]                             cmpl_resp,
    output logic                                   cmpl_len_err,
    output logic                                   err_unexp_rid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_W = LEN_W + 1;

    logic [MAX_OUTSTANDING-1:0] r_valid;
    logic [AXI_ID_W-1:0]        r_tag  [MAX_OUTSTANDING];
    logic [LEN_W-1:0]           r_len  [MAX_OUTSTANDING];
    logic [BEAT_W-1:0]          r_beat [MAX_OUTSTANDING];
    logic [1:0]                 r_resp_acc [MAX_OUTSTANDING];

    logic                       r_cmpl_valid;
    logic [AXI_ID_W-1:0]        r_cmpl_tag;
    logic [1:0]                 r_cmpl_resp;
    logic                       r_cmpl_len_err;
    logic                       r_err_unexp;
    logic [CNT_W-1:0]           r_outstanding;

    logic [MAX_OUTSTANDING-1:0] w_tag_hit;
    logic [MAX_OUTSTANDING-1:0] w_match;
    logic [MAX_OUTSTANDING-1:0] w_alloc_oh;
    logic                       w_alloc_found;
    logic [AXI_ID_W-1:0]        w_m_tag;
    logic [LEN_W-1:0]           w_m_len;
    logic [BEAT_W-1:0]          w_m_beat;
    logic [1:0]                 w_m_resp;
    logic [BEAT_W-1:0]          w_beat_inc;
    logic [1:0]                 w_resp_max;
    logic                       w_len_err;
    logic                       w_hit;
    logic                       w_free;
    logic                       w_alloc;
    logic                       w_any_free;

    // Tags are unique across valid slots, so at most one slot matches r_id.
    always_comb begin
        w_tag_hit     = '0;
        w_match       = '0;
        w_alloc_oh    = '0;
        w_alloc_found = 1'b0;
        w_m_tag       = '0;
        w_m_len       = '0;
        w_m_beat      = '0;
        w_m_resp      = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            w_tag_hit[i] = r_valid[i] && (r_tag[i] == fifo_tag);
            w_match[i]   = r_valid[i] && (r_tag[i] == r_id);
            if (!r_valid[i] && !w_alloc_found) begin
                w_alloc_oh[i] = 1'b1;
                w_alloc_found = 1'b1;
            end
            if (w_match[i]) begin
                w_m_tag  = r_tag[i];
                w_m_len  = r_len[i];
                w_m_beat = r_beat[i];
                w_m_resp = r_resp_acc[i];
            end
        end
    end

    assign w_any_free = !(&r_valid);
    assign bld_valid  = fifo_valid && w_any_free && !(|w_tag_hit);
    assign fifo_ready = bld_valid && bld_ready;

    assign w_hit      = |w_match;
    assign w_alloc    = fifo_ready;
    assign w_free     = r_fire && r_last && w_hit;
    assign w_beat_inc = (&w_m_beat) ? w_m_beat : (w_m_beat + BEAT_W'(1));
    assign w_resp_max = (r_resp > w_m_resp) ? r_resp : w_m_resp;
    assign w_len_err  = (w_beat_inc != ({1'b0, w_m_len} + BEAT_W'(1)));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid        <= '0;
            r_cmpl_valid   <= 1'b0;
            r_cmpl_tag     <= '0;
            r_cmpl_resp    <= '0;
            r_cmpl_len_err <= 1'b0;
            r_err_unexp    <= 1'b0;
            r_outstanding  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tag[i]      <= '0;
                r_len[i]      <= '0;
                r_beat[i]     <= '0;
                r_resp_acc[i] <= '0;
            end
        end else begin
            // A slot being allocated is invalid, so it can never also match a beat.
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (w_alloc && w_alloc_oh[i]) begin
                    r_valid[i]    <= 1'b1;
                    r_tag[i]      <= fifo_tag;
                    r_len[i]      <= fifo_len;
                    r_beat[i]     <= '0;
                    r_resp_acc[i] <= 2'b00;
                end else if (r_fire && w_match[i]) begin
                    r_beat[i]     <= w_beat_inc;
                    r_resp_acc[i] <= w_resp_max;
                    if (r_last) begin
                        r_valid[i] <= 1'b0;
                    end
                end
            end

            r_cmpl_valid   <= w_free;
            r_cmpl_len_err <= w_free && w_len_err;
            if (w_free) begin
                r_cmpl_tag  <= w_m_tag;
                r_cmpl_resp <= w_resp_max;
            end

            if (r_fire && !w_hit) begin
                r_err_unexp <= 1'b1;
            end

            if (w_alloc && !w_free) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_alloc && w_free) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end
        end
    end

    assign cmpl_valid    = r_cmpl_valid;
    assign cmpl_tag      = r_cmpl_tag;
    assign cmpl_resp     = r_cmpl_resp;
    assign cmpl_len_err  = r_cmpl_len_err;
    assign err_unexp_rid = r_err_unexp;
    assign outstanding   = r_outstanding;

endmodule
`default_nettype wire
